uart_matmul_engine: RTL

//  Parametrised NxN matrix-multiply engine fed by a UART byte stream. Receives

---
 rtl/matmul_pkg.sv | 56 +++++
 rtl/matmul_mac.sv | 52 +++++
 rtl/uart_matmul_engine.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// Shared definitions for the UART-fed matrix-multiply engine: FSM encoding,
// default widths and the accumulator-to-output saturation helper.
package matmul_pkg;

  typedef enum logic [2:0] {
    ST_RECEIVE_A = 3'd1,
    ST_RECEIVE_B = 3'd2,
    ST_COMPUTE   = 3'd3,
    ST_SEND_C    = 3'd4
  } state_e;

  localparam int DEF_N           = 3;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_TIMEOUT_CYC = 1_000_000;

  // Wide enough for any legal accumulator (2*32 + 3 bits).
  localparam int SAT_W = 128;

  typedef struct packed {
    logic             clamped;
    logic [SAT_W-1:0] value;
  } sat_t;

  // acc must arrive already sign- or zero-extended to SAT_W.
  function automatic sat_t sat_to_out(input logic [SAT_W-1:0] acc,
                                      input int               acc_w,
                                      input int               out_w,
                                      input bit               is_signed);
    sat_t             r;
    logic [SAT_W-1:0] max_v;
    logic [SAT_W-1:0] min_v;
    r.value   = acc;
    r.clamped = 1'b0;
    if (out_w < acc_w) begin
      if (is_signed) begin
        max_v = (SAT_W'(1) << (out_w - 1)) - SAT_W'(1);
        min_v = ~max_v;
        if ($signed(acc) > $signed(max_v)) begin
          r.value   = max_v;
          r.clamped = 1'b1;
        end else if ($signed(acc) < $signed(min_v)) begin
          r.value   = min_v;
          r.clamped = 1'b1;
        end
      end else begin
        max_v = (SAT_W'(1) << out_w) - SAT_W'(1);
        if (acc > max_v) begin
          r.value   = max_v;
          r.clamped = 1'b1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Single registered multiply-accumulate: acc <= (clr ? 0 : acc) + a*b,
// with operands treated as signed or unsigned and the product extended to ACC_W.
module matmul_mac #(
  parameter int DATA_W      = 8,
  parameter int ACC_W       = 18,
  parameter int SIGNED_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              clr,
  input  logic              en,
  output logic [ACC_W-1:0]  acc
);

  localparam int PROD_W = 2 * DATA_W;

  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  prod_ext;
  logic [ACC_W-1:0]  acc_q;

  generate
    if (SIGNED_MODE != 0) begin : g_signed
      logic signed [PROD_W-1:0] sa;
      logic signed [PROD_W-1:0] sb;
      assign sa       = PROD_W'($signed(a));
      assign sb       = PROD_W'($signed(b));
      assign prod     = $unsigned(sa * sb);
      assign prod_ext = ACC_W'($signed(prod));
    end else begin : g_unsigned
      logic [PROD_W-1:0] za;
      logic [PROD_W-1:0] zb;
      assign za       = PROD_W'(a);
      assign zb       = PROD_W'(b);
      assign prod     = za * zb;
      assign prod_ext = ACC_W'(prod);
    end
  endgenerate

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= clr ? prod_ext : acc_q + prod_ext;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/uart_matmul_engine.sv
// NxN matrix-multiply engine: receives A then B as little-endian byte streams,
// computes C = A*B with one sequential MAC and streams saturated C back out.
module uart_matmul_engine
  import matmul_pkg::*;
#(
  parameter int N           = DEF_N,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SIGNED_MODE = 0,
  parameter int ACC_W       = 2 * DATA_W + $clog2(N),
  parameter int OUT_W       = ACC_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ovf,
  output logic       frame_err,
  output logic [2:0] state
);

  localparam int BPE      = DATA_W / 8;
  localparam int OBPE     = (OUT_W + 7) / 8;
  localparam int PAD_W    = OBPE * 8;
  localparam int NN       = N * N;
  localparam int IN_BYTES = NN * BPE;
  localparam int BYTE_CW  = $clog2(IN_BYTES);
  localparam int IDX_W    = $clog2(N);
  localparam int ELEM_W   = $clog2(NN);
  localparam int LANE_W   = (OBPE > 1) ? $clog2(OBPE) : 1;
  localparam int TMO_W    = $clog2(TIMEOUT_CYC + 1);

  localparam logic [BYTE_CW-1:0] BYTE_LAST = BYTE_CW'(IN_BYTES - 1);
  localparam logic [IDX_W-1:0]   IDX_MAX   = IDX_W'(N - 1);
  localparam logic [ELEM_W-1:0]  ELEM_MAX  = ELEM_W'(NN - 1);
  localparam logic [LANE_W-1:0]  LANE_MAX  = LANE_W'(OBPE - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

  state_e              state_q;
  logic [BYTE_CW-1:0]  byte_cnt_q;
  logic [TMO_W-1:0]    tmo_cnt_q;
  logic [IDX_W-1:0]    i_q, j_q, k_q;
  logic                mac_done_q;
  logic                c_wr_q;
  logic [ELEM_W-1:0]   c_idx_q;
  logic [ELEM_W-1:0]   send_elem_q;
  logic [LANE_W-1:0]   send_lane_q;
  logic [7:0]          tx_data_q;
  logic                tx_valid_q;
  logic                done_q;
  logic                ovf_q;
  logic                frame_err_q;

  logic [7:0]        mem_a [IN_BYTES];
  logic [7:0]        mem_b [IN_BYTES];
  logic [OUT_W-1:0]  mem_c [NN];

  logic [ELEM_W-1:0]  a_elem, b_elem, cur_elem;
  logic [BYTE_CW-1:0] a_base, b_base;
  logic [DATA_W-1:0]  a_op, b_op;
  logic               mac_en;
  logic [ACC_W-1:0]   mac_acc;
  logic [SAT_W-1:0]   acc_ext;
  sat_t               sat_res;
  logic [OUT_W-1:0]   c_wr_word;
  logic               c_clamp;
  logic [ELEM_W-1:0]  nxt_elem_d;
  logic [LANE_W-1:0]  nxt_lane_d;
  logic               last_byte;
  logic [OUT_W-1:0]   c_rd_word;
  logic [PAD_W-1:0]   c_pad;
  logic [7:0]         nxt_byte_d;

  // Operand fetch: gather BPE little-endian bytes for A[i][k] and B[k][j].
  assign a_elem   = ELEM_W'(i_q * N + k_q);
  assign b_elem   = ELEM_W'(k_q * N + j_q);
  assign cur_elem = ELEM_W'(i_q * N + j_q);
  assign a_base   = BYTE_CW'(a_elem * BPE);
  assign b_base   = BYTE_CW'(b_elem * BPE);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    a_op = '0;
    b_op = '0;
    for (int l = 0; l < BPE; l++) begin
      a_op[8*l +: 8] = mem_a[a_base + BYTE_CW'(l)];
      b_op[8*l +: 8] = mem_b[b_base + BYTE_CW'(l)];
    end
  end

  assign mac_en = (state_q == ST_COMPUTE) && !mac_done_q;

  matmul_mac #(
    .DATA_W      (DATA_W),
    .ACC_W       (ACC_W),
    .SIGNED_MODE (SIGNED_MODE)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a_op),
    .b     (b_op),
    .clr   (k_q == '0),
    .en    (mac_en),
    .acc   (mac_acc)
  );

  always_comb begin
    acc_ext = (SIGNED_MODE != 0) ? SAT_W'($signed(mac_acc)) : SAT_W'(mac_acc);
    sat_res   = sat_to_out(acc_ext, ACC_W, OUT_W, SIGNED_MODE != 0);
    c_wr_word = OUT_W'(sat_res.value);
    c_clamp   = sat_res.clamped;
  end

  // Byte sequencer for C: outside SEND_C it points at the first byte so the
  // COMPUTE->SEND_C transition can preload it.
  always_comb begin
    nxt_elem_d = '0;
    nxt_lane_d = '0;
    if (state_q == ST_SEND_C) begin
      if (send_lane_q == LANE_MAX) begin
        nxt_elem_d = send_elem_q + ELEM_W'(1);
      end else begin
        nxt_elem_d = send_elem_q;
        nxt_lane_d = send_lane_q + LANE_W'(1);
      end
    end
  end

  assign last_byte  = (send_elem_q == ELEM_MAX) && (send_lane_q == LANE_MAX);
  assign c_rd_word  = mem_c[nxt_elem_d];
  assign c_pad      = (SIGNED_MODE != 0) ? PAD_W'($signed(c_rd_word)) : PAD_W'(c_rd_word);
  assign nxt_byte_d = c_pad[{nxt_lane_d, 3'b000} +: 8];

  // NOTE: the matrix arrays are plain storage and deliberately have no reset.
  always_ff @(posedge clk) begin
    if (rx_valid && state_q == ST_RECEIVE_A) mem_a[byte_cnt_q] <= rx_data;
    if (rx_valid && state_q == ST_RECEIVE_B) mem_b[byte_cnt_q] <= rx_data;
    if (c_wr_q) mem_c[c_idx_q] <= c_wr_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RECEIVE_A;
      byte_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      mac_done_q  <= 1'b0;
      c_wr_q      <= 1'b0;
      c_idx_q     <= '0;
      send_elem_q <= '0;
      send_lane_q <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
      c_wr_q      <= 1'b0;
      unique case (state_q)
        ST_RECEIVE_A, ST_RECEIVE_B: begin
          if (rx_valid) begin
            tmo_cnt_q <= '0;
            if (byte_cnt_q == BYTE_LAST) begin
              byte_cnt_q <= '0;
              if (state_q == ST_RECEIVE_A) begin
                state_q <= ST_RECEIVE_B;
              end else begin
                state_q    <= ST_COMPUTE;
                ovf_q      <= 1'b0;
                i_q        <= '0;
                j_q        <= '0;
                k_q        <= '0;
                mac_done_q <= 1'b0;
              end
            end else begin
              byte_cnt_q <= byte_cnt_q + BYTE_CW'(1);
            end
          end else if (byte_cnt_q != '0) begin
            if (tmo_cnt_q == TMO_LAST) begin
              frame_err_q <= 1'b1;
              byte_cnt_q  <= '0;
              tmo_cnt_q   <= '0;
              state_q     <= ST_RECEIVE_A;
            end else begin
              tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            end
          end
        end
        ST_COMPUTE: begin
          if (!mac_done_q) begin
            // The accumulator for C[i][j] is complete one cycle after k=N-1 is fed.
            c_wr_q  <= (k_q == IDX_MAX);
            c_idx_q <= cur_elem;
            if (k_q == IDX_MAX) begin
              k_q <= '0;
              if (j_q == IDX_MAX) begin
                j_q <= '0;
                if (i_q == IDX_MAX) mac_done_q <= 1'b1;
                else                i_q <= i_q + IDX_W'(1);
              end else begin
                j_q <= j_q + IDX_W'(1);
              end
            end else begin
              k_q <= k_q + IDX_W'(1);
            end
          end else begin
            state_q     <= ST_SEND_C;
            tx_valid_q  <= 1'b1;
            tx_data_q   <= nxt_byte_d;
            send_elem_q <= '0;
            send_lane_q <= '0;
          end
        end
        ST_SEND_C: begin
          if (tx_ready) begin
            if (last_byte) begin
              tx_valid_q <= 1'b0;
              tx_data_q  <= '0;
              done_q     <= 1'b1;
              state_q    <= ST_RECEIVE_A;
            end else begin
              tx_data_q   <= nxt_byte_d;
              send_elem_q <= nxt_elem_d;
              send_lane_q <= nxt_lane_d;
            end
          end
        end
        default: state_q <= ST_RECEIVE_A;
      endcase
      if (c_wr_q && c_clamp) ovf_q <= 1'b1;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign busy      = (state_q == ST_COMPUTE) || (state_q == ST_SEND_C);
  assign done      = done_q;
  assign ovf       = ovf_q;
  assign frame_err = frame_err_q;
  assign state     = state_q;

endmodule
